// File: rtl/pmem_pkg.sv
// Shared definitions for the multi-port line memory: parameter defaults,
// controller state encoding and line/mask types.
package pmem_pkg;

  localparam int DEF_NUM_PORTS   = 2;
  localparam int DEF_LINE_BITS   = 128;
  localparam int DEF_ADDR_BITS   = 16;
  localparam int DEF_DEPTH_LINES = 4096;
  localparam int DEF_LATENCY     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } pmem_state_t;

  typedef logic [DEF_LINE_BITS-1:0]   pmem_line_t;
  typedef logic [DEF_LINE_BITS/8-1:0] pmem_mask_t;

  // Width of an index into n items; a single item still needs one bit.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: first requester at or after the
// pointer, wrapping from N-1 back to 0.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          valid_o
);

  localparam int CW = IW + 1;

  logic [CW-1:0] sum_s;
  logic [IW-1:0] cand_s;
  logic          hit_s;

  // Scan from the pointer and keep the first hit.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    valid_o   = 1'b0;
    sum_s     = '0;
    cand_s    = '0;
    hit_s     = 1'b0;
    for (int i = 0; i < N; i++) begin
      sum_s     = CW'(ptr_i) + CW'(i);
      sum_s     = (sum_s >= CW'(N)) ? (sum_s - CW'(N)) : sum_s;
      cand_s    = sum_s[IW-1:0];
      hit_s     = req_i[cand_s] & ~valid_o;
      gnt_o[cand_s] = gnt_o[cand_s] | hit_s;
      gnt_idx_o = hit_s ? cand_s : gnt_idx_o;
      valid_o   = valid_o | hit_s;
    end
  end

endmodule

// File: rtl/multiport_pmem.sv
// Multi-port line memory: round-robin grant, fixed grant-to-response
// latency, byte-masked writes committed in the response cycle.
module multiport_pmem
  import pmem_pkg::*;
#(
  parameter int NUM_PORTS   = DEF_NUM_PORTS,
  parameter int LINE_BITS   = DEF_LINE_BITS,
  parameter int ADDR_BITS   = DEF_ADDR_BITS,
  parameter int DEPTH_LINES = DEF_DEPTH_LINES,
  parameter int LATENCY     = DEF_LATENCY
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_PORTS-1:0]                  read_i,
  input  logic [NUM_PORTS-1:0]                  write_i,
  input  logic [NUM_PORTS-1:0][ADDR_BITS-1:0]   address_i,
  input  logic [NUM_PORTS-1:0][LINE_BITS-1:0]   wdata_i,
  input  logic [NUM_PORTS-1:0][LINE_BITS/8-1:0] byte_enable_i,
  output logic [NUM_PORTS-1:0]                  resp_o,
  output logic [LINE_BITS-1:0]                  rdata_o,
  output logic                                  busy_o,
  output logic                                  proto_err_o
);

  localparam int BYTES = LINE_BITS / 8;
  localparam int OFF   = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH_LINES);
  localparam int PW    = idx_bits(NUM_PORTS);

  pmem_state_t              state_q, state_d;
  logic [7:0]               count_q, count_d;
  logic [PW-1:0]            rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]            gnt_q, gnt_d;
  logic [NUM_PORTS-1:0]     gnt_oh_q, gnt_oh_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [LINE_BITS-1:0]     wdata_q, wdata_d;
  logic [BYTES-1:0]         be_q, be_d;
  logic                     is_write_q, is_write_d;
  logic [NUM_PORTS-1:0]     resp_q, resp_d;
  logic [LINE_BITS-1:0]     rdata_q, rdata_d;
  logic                     busy_q, busy_d;
  logic                     proto_err_q, proto_err_d;

  logic [LINE_BITS-1:0]     mem_q [DEPTH_LINES];

  logic [NUM_PORTS-1:0]     req_s;
  logic [NUM_PORTS-1:0]     gnt_oh_s;
  logic [PW-1:0]            gnt_idx_s;
  logic                     gnt_valid_s;
  logic [ADDR_BITS-1:0]     line_addr_s;
  logic                     unused_addr_s;

  assign req_s         = read_i | write_i;
  assign line_addr_s   = address_i[gnt_idx_s] >> OFF;
  assign unused_addr_s = ^line_addr_s;

  rr_arbiter #(
    .N  (NUM_PORTS),
    .IW (PW)
  ) u_arb (
    .req_i     (req_s),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt_oh_s),
    .gnt_idx_o (gnt_idx_s),
    .valid_o   (gnt_valid_s)
  );

  // Next-state and next-output logic; outputs are registered from the next state.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    gnt_oh_d    = gnt_oh_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    is_write_d  = is_write_q;
    proto_err_d = proto_err_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid_s) begin
          gnt_d       = gnt_idx_s;
          gnt_oh_d    = gnt_oh_s;
          idx_d       = line_addr_s[IDX_W-1:0];
          wdata_d     = wdata_i[gnt_idx_s];
          be_d        = byte_enable_i[gnt_idx_s];
          is_write_d  = write_i[gnt_idx_s];
          proto_err_d = proto_err_q | (read_i[gnt_idx_s] & write_i[gnt_idx_s]);
          count_d     = 8'(LATENCY - 1);
          state_d     = (LATENCY == 1) ? RESP : BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        // Dropping the request is only legal once resp has been seen.
        proto_err_d = proto_err_q | ~req_s[gnt_q];
        count_d     = (count_q == 8'd0) ? 8'd0 : (count_q - 8'd1);
        if (count_q <= 8'd1) begin
          state_d = RESP;
        end else begin
          state_d = BUSY;
        end
      end
      RESP: begin
        rr_ptr_d = (gnt_q == PW'(NUM_PORTS - 1)) ? '0 : (gnt_q + PW'(1));
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    resp_d  = (state_d == RESP) ? gnt_oh_d : '0;
    rdata_d = ((state_d == RESP) && !is_write_d) ? mem_q[idx_d] : '0;
    busy_d  = (state_d != IDLE);
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= 8'd0;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      gnt_oh_q    <= '0;
      idx_q       <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      is_write_q  <= 1'b0;
      resp_q      <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
      gnt_oh_q    <= gnt_oh_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      is_write_q  <= is_write_d;
      resp_q      <= resp_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Storage: masked write leaves the response cycle; reset aborts it via state_q.
  always_ff @(posedge clk) begin
    if ((state_q == RESP) && is_write_q) begin
      for (int b = 0; b < BYTES; b++) begin
        if (be_q[b]) begin
          mem_q[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
        end
      end
    end
  end

  assign resp_o      = resp_q;
  assign rdata_o     = rdata_q;
  assign busy_o      = busy_q;
  assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_multiport_pmem.sv
// Directed bench: default two-port instance plus a small single-port,
// latency-1, 16-line instance for the aliasing and minimum-latency cases.
module tb_multiport_pmem;
  import pmem_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]         read_s, write_s;
  logic [1:0][15:0]   addr_s;
  logic [1:0][127:0]  wdata_s;
  logic [1:0][15:0]   be_s;
  logic [1:0]         resp_s;
  logic [127:0]       rdata_s;
  logic               busy_s, perr_s;

  logic [0:0]         r2_s, w2_s;
  logic [0:0][15:0]   a2_s;
  logic [0:0][127:0]  d2_s;
  logic [0:0][15:0]   b2_s;
  logic [0:0]         resp2_s;
  logic [127:0]       rdata2_s;
  logic               busy2_s, perr2_s;

  int errors = 0;
  int checks = 0;

  multiport_pmem dut (
    .clk(clk), .rst_n(rst_n), .read_i(read_s), .write_i(write_s),
    .address_i(addr_s), .wdata_i(wdata_s), .byte_enable_i(be_s),
    .resp_o(resp_s), .rdata_o(rdata_s), .busy_o(busy_s), .proto_err_o(perr_s)
  );

  multiport_pmem #(.NUM_PORTS(1), .DEPTH_LINES(16), .LATENCY(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .read_i(r2_s), .write_i(w2_s),
    .address_i(a2_s), .wdata_i(d2_s), .byte_enable_i(b2_s),
    .resp_o(resp2_s), .rdata_o(rdata2_s), .busy_o(busy2_s), .proto_err_o(perr2_s)
  );

  task automatic do_reset();
    rst_n = 1'b0;
    read_s = '0; write_s = '0; r2_s = '0; w2_s = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issue one request on the default instance and wait for its resp.
  task automatic txn(input int p, input logic rd, input logic wr, input logic [15:0] a,
                     input pmem_line_t d, input pmem_mask_t be,
                     output pmem_line_t data, output int cyc);
    read_s[p] = rd; write_s[p] = wr; addr_s[p] = a; wdata_s[p] = d; be_s[p] = be;
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
    end while (!resp_s[p] && cyc < 200);
    data = rdata_s;
    checks++;
    if (resp_s[p] !== 1'b1) begin
      errors++; $display("FAIL txn_timeout port=%0d got resp=%b want 1", p, resp_s[p]);
    end
    read_s[p] = 1'b0; write_s[p] = 1'b0;
  endtask

  task automatic txn2(input logic rd, input logic wr, input logic [15:0] a,
                      input pmem_line_t d, output pmem_line_t data, output int cyc);
    r2_s[0] = rd; w2_s[0] = wr; a2_s[0] = a; d2_s[0] = d; b2_s[0] = 16'hFFFF;
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
    end while (!resp2_s[0] && cyc < 50);
    data = rdata2_s;
    checks++;
    if (resp2_s[0] !== 1'b1) begin
      errors++; $display("FAIL txn2_timeout got resp=%b want 1", resp2_s[0]);
    end
    r2_s[0] = 1'b0; w2_s[0] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    read_s = '0; write_s = '0; addr_s = '0; wdata_s = '0; be_s = '0;
    r2_s = '0; w2_s = '0; a2_s = '0; d2_s = '0; b2_s = '0;
    #3;
    checks++; if (resp_s !== 2'b00) begin errors++; $display("FAIL reset_resp got %b want 00", resp_s); end
    checks++; if (rdata_s !== 128'd0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata_s); end
    checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_s); end
    checks++; if (perr_s !== 1'b0) begin errors++; $display("FAIL reset_perr got %b want 0", perr_s); end
    do_reset();
  endtask

  task automatic test_write_read();
    pmem_line_t d; int c;
    txn(0, 1'b0, 1'b1, 16'h0040, {16{8'hAA}}, 16'hFFFF, d, c);
    checks++; if (c !== 8) begin errors++; $display("FAIL wr_latency got %0d want 8", c); end
    checks++; if (busy_s !== 1'b1) begin errors++; $display("FAIL resp_busy got %b want 1", busy_s); end
    checks++; if (d !== 128'd0) begin errors++; $display("FAIL wr_rdata got %h want 0", d); end
    txn(0, 1'b1, 1'b0, 16'h0040, '0, '0, d, c);
    checks++; if (c !== 9) begin errors++; $display("FAIL rd_latency got %0d want 9", c); end
    checks++; if (d !== {16{8'hAA}}) begin errors++; $display("FAIL rd_data got %h want aa..aa", d); end
    @(posedge clk); #1;
    checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy_s); end
    checks++; if (rdata_s !== 128'd0) begin errors++; $display("FAIL idle_rdata got %h want 0", rdata_s); end
  endtask

  task automatic test_mask();
    pmem_line_t d; int c;
    txn(0, 1'b0, 1'b1, 16'h0100, {16{8'h11}}, 16'hFFFF, d, c);
    txn(0, 1'b0, 1'b1, 16'h0100, {16{8'hFF}}, 16'h0001, d, c);
    txn(0, 1'b1, 1'b0, 16'h0100, '0, '0, d, c);
    checks++; if (d !== {{15{8'h11}}, 8'hFF}) begin errors++; $display("FAIL mask_data got %h want 11..11ff", d); end
  endtask

  task automatic test_round_robin();
    int port_q[4]; int cyc_q[4]; pmem_line_t data_q[4];
    int n; int exp_cyc;
    pmem_line_t exp_d;
    do_reset();
    addr_s[0] = 16'h0040; addr_s[1] = 16'h0100;
    read_s = 2'b11;
    n = 0;
    for (int c = 1; c <= 100 && n < 4; c++) begin
      @(posedge clk); #1;
      if (resp_s == 2'b11) begin
        checks++; errors++; $display("FAIL rr_onehot got %b want one port", resp_s);
      end
      if (resp_s != 2'b00) begin
        port_q[n] = resp_s[1] ? 1 : 0; cyc_q[n] = c; data_q[n] = rdata_s; n++;
      end
    end
    read_s = 2'b00;
    checks++; if (n !== 4) begin errors++; $display("FAIL rr_count got %0d want 4", n); end
    for (int i = 0; i < n; i++) begin
      exp_cyc = 8 + 9 * i;
      exp_d = (i % 2 == 0) ? {16{8'hAA}} : {{15{8'h11}}, 8'hFF};
      checks++; if (port_q[i] !== i % 2) begin errors++; $display("FAIL rr_port[%0d] got %0d want %0d", i, port_q[i], i % 2); end
      checks++; if (cyc_q[i] !== exp_cyc) begin errors++; $display("FAIL rr_cycle[%0d] got %0d want %0d", i, cyc_q[i], exp_cyc); end
      checks++; if (data_q[i] !== exp_d) begin errors++; $display("FAIL rr_data[%0d] got %h want %h", i, data_q[i], exp_d); end
    end
    checks++; if (perr_s !== 1'b0) begin errors++; $display("FAIL rr_perr got %b want 0", perr_s); end
  endtask

  task automatic test_proto_err();
    pmem_line_t d; int c;
    txn(0, 1'b1, 1'b1, 16'h0300, {16{8'h55}}, 16'hFFFF, d, c);
    checks++; if (perr_s !== 1'b1) begin errors++; $display("FAIL rw_perr got %b want 1", perr_s); end
    checks++; if (d !== 128'd0) begin errors++; $display("FAIL rw_rdata got %h want 0", d); end
    txn(1, 1'b1, 1'b0, 16'h0300, '0, '0, d, c);
    checks++; if (d !== {16{8'h55}}) begin errors++; $display("FAIL rw_commit got %h want 55..55", d); end
    repeat (5) @(posedge clk); #1;
    checks++; if (perr_s !== 1'b1) begin errors++; $display("FAIL perr_sticky got %b want 1", perr_s); end
  endtask

  task automatic test_drop();
    pmem_line_t d; int c; logic seen;
    do_reset();
    checks++; if (perr_s !== 1'b0) begin errors++; $display("FAIL drop_perr_init got %b want 0", perr_s); end
    write_s[1] = 1'b1; addr_s[1] = 16'h0400; wdata_s[1] = {16{8'h77}}; be_s[1] = 16'hFFFF;
    repeat (3) @(posedge clk); #1;
    write_s[1] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      seen = resp_s[1];
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL drop_resp got %b want 1", seen); end
    checks++; if (perr_s !== 1'b1) begin errors++; $display("FAIL drop_perr got %b want 1", perr_s); end
    txn(0, 1'b1, 1'b0, 16'h0400, '0, '0, d, c);
    checks++; if (d !== {16{8'h77}}) begin errors++; $display("FAIL drop_commit got %h want 77..77", d); end
  endtask

  task automatic test_reset_inflight();
    pmem_line_t d; int c; int pulses;
    do_reset();
    txn(0, 1'b0, 1'b1, 16'h0200, {16{8'h33}}, 16'hFFFF, d, c);
    write_s[0] = 1'b1; addr_s[0] = 16'h0200; wdata_s[0] = {16{8'hCC}}; be_s[0] = 16'hFFFF;
    repeat (2) @(posedge clk);
    repeat (3) @(posedge clk); #1;
    checks++; if (busy_s !== 1'b1) begin errors++; $display("FAIL inflight_busy got %b want 1", busy_s); end
    rst_n = 1'b0; #1;
    checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL arst_busy got %b want 0", busy_s); end
    checks++; if ({resp_s, rdata_s, perr_s} !== 131'd0) begin errors++; $display("FAIL arst_outputs got %b/%h/%b want 0", resp_s, rdata_s, perr_s); end
    write_s[0] = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (resp_s[0]) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL arst_resp got %0d pulses want 0", pulses); end
    @(negedge clk); rst_n = 1'b1;
    txn(0, 1'b1, 1'b0, 16'h0200, '0, '0, d, c);
    checks++; if (d !== {16{8'h33}}) begin errors++; $display("FAIL arst_discard got %h want 33..33", d); end
  endtask

  task automatic test_alias_lat1();
    pmem_line_t d; int c;
    txn2(1'b0, 1'b1, 16'h0100, {16{8'h5A}}, d, c);
    checks++; if (c !== 1) begin errors++; $display("FAIL lat1_wr got %0d want 1", c); end
    txn2(1'b1, 1'b0, 16'h0000, '0, d, c);
    checks++; if (c !== 2) begin errors++; $display("FAIL lat1_rd got %0d want 2", c); end
    checks++; if (d !== {16{8'h5A}}) begin errors++; $display("FAIL alias_data got %h want 5a..5a", d); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_mask();
    test_round_robin();
    test_proto_err();
    test_drop();
    test_reset_inflight();
    test_alias_lat1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multiport_pmem.md
MULTIPORT_PMEM -- requirements
Module: multiport_pmem

Interface
REQ-001 Parameter NUM_PORTS, default 2: number of independent requester channels; legal range 1..8.
REQ-002 Parameter LINE_BITS, default 128: data width of one memory line; multiple of 8.
REQ-003 Parameter ADDR_BITS, default 16: byte-address width.
REQ-004 Parameter DEPTH_LINES, default 4096: number of stored lines; power of two.
REQ-005 Parameter LATENCY, default 8: cycles from grant to resp; legal range 1..255.
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 rst_n  input  1  reset, asynchronous and active-low.
REQ-008 read  input  [NUM_PORTS]  per-port read request, held until that port's resp.
REQ-009 write  input  [NUM_PORTS]  per-port write request, held until that port's resp.
REQ-010 address  input  [NUM_PORTS][ADDR_BITS]  per-port byte address; low log2(LINE_BITS/8) bits ignored.
REQ-011 wdata  input  [NUM_PORTS][LINE_BITS]  per-port write line.
REQ-012 byte_enable  input  [NUM_PORTS][LINE_BITS/8]  per-port byte write mask, 1 = write byte.
REQ-013 resp  output  [NUM_PORTS]  one-cycle completion pulse for the granted port.
REQ-014 rdata  output  [LINE_BITS]  shared read line, valid only in the resp cycle.
REQ-015 busy  output  1  high while a transaction is in flight.
REQ-016 proto_err  output  1  sticky protocol-error flag.

Function
REQ-017 FSM states IDLE, BUSY, RESP; exactly one transaction in flight at a time.
REQ-018 IDLE: when any port has read|write, grant the first requesting port at or after rr_ptr (round-robin, wrapping at NUM_PORTS-1 to 0), capture its address, wdata, byte_enable and op, load count = LATENCY-1, go to BUSY; otherwise stay in IDLE.
REQ-019 BUSY: decrement count each cycle; at count 0 go to RESP.
REQ-020 Latency: grant in cycle t, resp[granted] high in cycle t+LATENCY, and for reads rdata holds the line at the captured index in that same cycle.
REQ-021 RESP: pulse resp for one cycle, commit any write using the byte mask, set rr_ptr = (granted+1) mod NUM_PORTS, and return to IDLE. A new grant is not made in the RESP cycle.
REQ-022 Line index = captured address[ADDR_BITS-1:log2(LINE_BITS/8)] mod DEPTH_LINES (wraps).
REQ-023 Writes commit only the bytes whose byte_enable bit is 1; all other bytes are unchanged.
REQ-024 A read in the RESP cycle immediately after a write to the same line returns the updated data.
REQ-025 If read and write are both asserted on the granted port, set proto_err and execute a write.
REQ-026 If the granted port drops its request before resp, the transaction still completes with the captured values, resp still pulses, and proto_err is set.
REQ-027 Non-granted ports with requests wait with resp low; there is no starvation, so the worst-case wait is NUM_PORTS*(LATENCY+1) cycles.
REQ-028 busy is high in the BUSY and RESP states.
REQ-029 rdata is all zero outside a read resp cycle.

Reset
REQ-030 On rst_n low: state=IDLE, rr_ptr=0, count=0, resp=0, rdata=0, busy=0, proto_err=0, asynchronously.
REQ-031 Memory array contents are not cleared by reset; a write in flight at reset is discarded (not committed).
REQ-032 The first grant can occur in the first rising edge after rst_n deasserts.

Structure
REQ-033 Package pmem_pkg holds the parameter defaults, the pmem_state_t enum (IDLE, BUSY, RESP) and the line/mask typedefs.
REQ-034 Round-robin selection is sub-module rr_arbiter (request vector plus pointer in; one-hot grant plus index out, combinational).
REQ-035 The storage array is inferred inside multiport_pmem.

Verification
REQ-036 Single port, LATENCY=8: write 0xAAAA...AA with all-ones mask to 0x0040 at t, then read 0x0040 -> resp at t+8, read resp 9 cycles later, rdata=0xAA...AA.
REQ-037 Mask test: write 0x11..11 to 0x0100, then 0xFF..FF with byte_enable=0x0001 -> readback has byte0=0xFF and the rest 0x11.
REQ-038 Both ports read continuously from reset -> grants alternate 0,1,0,1; each port sees resp every 2*(LATENCY+1) cycles.
REQ-039 Port 0 asserts read and write together -> proto_err=1 and the write commits; proto_err stays 1 until reset.
REQ-040 rst_n low 3 cycles after a write grant to 0x0200 -> resp never pulses, the old line at 0x0200 is unchanged, and all outputs return to 0.
REQ-041 With DEPTH_LINES=16, a write to 0x0100 aliases to index 0 -> a read of 0x0000 returns that data.
